// File: rtl/cve2_mem_arbiter.sv
// Two-master OBI arbiter: shares one memory port between cve2 instruction fetch
// and data load/store, with an in-order ID FIFO for routing responses back.
module cve2_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          RoundRobin     = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,

    input  logic                                 instr_req_i,
    input  logic [31:0]                          instr_addr_i,
    output logic                                 instr_gnt_o,
    output logic                                 instr_rvalid_o,
    output logic [31:0]                          instr_rdata_o,
    output logic                                 instr_err_o,

    input  logic                                 data_req_i,
    input  logic                                 data_we_i,
    input  logic [3:0]                           data_be_i,
    input  logic [31:0]                          data_addr_i,
    input  logic [31:0]                          data_wdata_i,
    output logic                                 data_gnt_o,
    output logic                                 data_rvalid_o,
    output logic [31:0]                          data_rdata_o,
    output logic                                 data_err_o,

    output logic                                 mem_req_o,
    input  logic                                 mem_gnt_i,
    output logic                                 mem_we_o,
    output logic [3:0]                           mem_be_o,
    output logic [31:0]                          mem_addr_o,
    output logic [31:0]                          mem_wdata_o,
    input  logic                                 mem_rvalid_i,
    input  logic [31:0]                          mem_rdata_i,
    input  logic                                 mem_err_i,

    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 unexpected_rsp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

    localparam logic SelInstr = 1'b0;
    localparam logic SelData  = 1'b1;

    logic [MaxOutstanding-1:0] r_fifo;
    logic [PtrW-1:0]           r_wptr;
    logic [PtrW-1:0]           r_rptr;
    logic [CntW-1:0]           r_count;
    logic                      r_locked;
    logic                      r_locked_sel;
    logic                      r_last_gnt;
    logic                      r_unexp;

    logic w_sel;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // A pending (ungranted) request keeps its master so address/control stay stable.
    always_comb begin
        w_sel = SelInstr;
        if (r_locked) begin
            w_sel = r_locked_sel;
        end else if (instr_req_i && data_req_i) begin
            w_sel = RoundRobin ? ~r_last_gnt : SelData;
        end else if (data_req_i) begin
            w_sel = SelData;
        end
    end

    assign w_sel_req = (w_sel == SelData) ? data_req_i : instr_req_i;
    assign w_full    = (r_count >= MaxCnt);
    assign w_empty   = (r_count == '0);
    assign mem_req_o = w_sel_req && !w_full;
    assign w_push    = mem_req_o && mem_gnt_i;
    assign w_pop     = mem_rvalid_i && !w_empty;
    assign w_head    = r_fifo[r_rptr];

    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'hF;
        mem_wdata_o = '0;
        if (w_sel == SelData) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = w_push && (w_sel == SelInstr);
    assign data_gnt_o  = w_push && (w_sel == SelData);

    // A stray response (empty FIFO) is routed nowhere.
    assign instr_rvalid_o = w_pop && (w_head == SelInstr);
    assign data_rvalid_o  = w_pop && (w_head == SelData);
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o    = r_count;
    assign unexpected_rsp_o = r_unexp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fifo       <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_locked     <= 1'b0;
            r_locked_sel <= SelInstr;
            r_last_gnt   <= SelInstr;
            r_unexp      <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= ptr_next(r_wptr);
                r_last_gnt     <= w_sel;
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (mem_gnt_i) begin
                r_locked <= 1'b0;
            end else if (mem_req_o) begin
                r_locked     <= 1'b1;
                r_locked_sel <= w_sel;
            end

            if (mem_rvalid_i && w_empty) begin
                r_unexp <= 1'b1;
            end
        end
    end

endmodule
